// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
//   Shared definitions for the data-bus arbiter and any other block that needs
//   a round-robin pick (for example the interrupt controller).
//   - IDLE / OWN      : arbiter FSM state encodings
//   - MAX_REQ         : widest requester vector the helpers support
//   - ID_WIDTH        : width of an encoded requester index
//   - rr_result_t     : winner index plus valid flag
//   - next_rr()       : round-robin search starting after last_owner
//   - cnt_width()     : counter width able to hold 0..max_burst-1
package bus_arb_pkg;

    localparam int MAX_REQ  = 8;
    localparam int ID_WIDTH = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] idx;
    } rr_result_t;

    // Scans num_req requesters starting at last_owner+1 and wrapping, so the
    // previous owner is considered last. Bits at or above num_req are ignored.
    function automatic rr_result_t next_rr(
        input logic [MAX_REQ-1:0]  req,
        input logic [ID_WIDTH-1:0] last_owner,
        input int unsigned         num_req
    );
        rr_result_t  r;
        int unsigned cand;
        r = '0;
        for (int unsigned off = 1; off <= MAX_REQ; off++) begin
            if (off <= num_req) begin
                cand = (int'(last_owner) + off) % num_req;
                if (!r.valid && req[cand[ID_WIDTH-1:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = cand[ID_WIDTH-1:0];
                end
            end
        end
        return r;
    endfunction

    function automatic int cnt_width(input int max_burst);
        return (max_burst <= 2) ? 1 : $clog2(max_burst);
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin priority selector.
//   Ports:
//     req        in  NUM_REQ   request vector
//     last_owner in  3         index searched last (search starts one above)
//     valid      out 1         at least one request present
//     onehot     out NUM_REQ   one-hot winner (zero when !valid)
//     idx        out 3         encoded winner
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_owner,
    output logic                valid,
    output logic [NUM_REQ-1:0]  onehot,
    output logic [ID_WIDTH-1:0] idx
);

    logic [MAX_REQ-1:0] req_ext;
    rr_result_t         res;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        res                    = next_rr(req_ext, last_owner, NUM_REQ);
        valid                  = res.valid;
        idx                    = res.idx;
        onehot                 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            onehot[i] = res.valid && (res.idx == ID_WIDTH'(i));
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Round-robin arbiter plus bus multiplexer sharing one data-memory /
//   peripheral port between NUM_REQ masters, with burst limit and lock.
//   Ports:
//     clk, rst             clock; synchronous active-low reset
//     req, lock            per-master request / lock
//     ce_in, wbe_in        per-master chip enable / byte enables (slice i)
//     addr_in, wdata_in    per-master address / write data (slice i)
//     gnt, gnt_id, busy    registered one-hot grant, encoded owner, owned flag
//     ce_out, wbe_out      shared-port chip enable / byte enables
//     addr_out, wdata_out  shared-port address / write data
//     rdata_in, rdata_out  read data, broadcast unregistered to all masters
module data_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              lock,
    input  logic [NUM_REQ-1:0]              ce_in,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] wbe_in,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_in,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [ID_WIDTH-1:0]             gnt_id,
    output logic                            busy,
    output logic                            ce_out,
    output logic [DATA_WIDTH/8-1:0]         wbe_out,
    output logic [ADDR_WIDTH-1:0]           addr_out,
    output logic [DATA_WIDTH-1:0]           wdata_out,
    input  logic [DATA_WIDTH-1:0]           rdata_in,
    output logic [DATA_WIDTH-1:0]           rdata_out
);

    localparam int                   WBE_W     = DATA_WIDTH / 8;
    localparam int                   CNT_WIDTH = cnt_width(MAX_BURST);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_BURST - 1);

    logic [0:0]           state;
    logic [ID_WIDTH-1:0]  last_owner;
    logic [CNT_WIDTH-1:0] burst_cnt;

    logic [NUM_REQ-1:0]   pick_req;
    logic                 pick_valid;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [ID_WIDTH-1:0]  pick_idx;
    logic                 owner_req;
    logic                 owner_lock;
    logic                 burst_done;

    assign busy = (state == OWN);

    // While owned, the owner is masked out so the picker only ever names a
    // different master; last_owner equals the owner, so the search starts
    // just after it.
    assign pick_req   = busy ? (req & ~gnt) : req;
    assign owner_req  = |(req & gnt);
    assign owner_lock = |(lock & gnt);
    assign burst_done = (burst_cnt == MAX_CNT);

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (pick_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .onehot     (pick_onehot),
        .idx        (pick_idx)
    );

    // ---- grant register stage ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_id     <= '0;
            burst_cnt  <= '0;
            last_owner <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state      <= OWN;
                        gnt        <= pick_onehot;
                        gnt_id     <= pick_idx;
                        last_owner <= pick_idx;
                        burst_cnt  <= '0;
                    end
                end
                default: begin
                    if (owner_req) begin
                        if (burst_done && !owner_lock && pick_valid) begin
                            gnt        <= pick_onehot;
                            gnt_id     <= pick_idx;
                            last_owner <= pick_idx;
                            burst_cnt  <= '0;
                        end else if (!burst_done) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (pick_valid) begin
                        gnt        <= pick_onehot;
                        gnt_id     <= pick_idx;
                        last_owner <= pick_idx;
                        burst_cnt  <= '0;
                    end else begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        burst_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // ---- combinational port mux stage ----
    // gnt is zero whenever the bus is idle, so an AND-OR over the one-hot
    // grant also yields zeros on every shared output when nobody owns it.
    always_comb begin
        ce_out    = 1'b0;
        wbe_out   = '0;
        addr_out  = '0;
        wdata_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                ce_out    = ce_out    | ce_in[i];
                wbe_out   = wbe_out   | wbe_in[i*WBE_W +: WBE_W];
                addr_out  = addr_out  | addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_out = wdata_out | wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rdata_out = rdata_in;

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int MAX_BURST  = 8;
    localparam int WBE_W      = DATA_WIDTH / 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ-1:0]            ce_in;
    logic [NUM_REQ*WBE_W-1:0]      wbe_in;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in;
    logic [NUM_REQ-1:0]            gnt;
    logic [2:0]                    gnt_id;
    logic                          busy;
    logic                          ce_out;
    logic [WBE_W-1:0]              wbe_out;
    logic [ADDR_WIDTH-1:0]         addr_out;
    logic [DATA_WIDTH-1:0]         wdata_out;
    logic [DATA_WIDTH-1:0]         rdata_in;
    logic [DATA_WIDTH-1:0]         rdata_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_bus_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .ce_in     (ce_in),
        .wbe_in    (wbe_in),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .ce_out    (ce_out),
        .wbe_out   (wbe_out),
        .addr_out  (addr_out),
        .wdata_out (wdata_out),
        .rdata_in  (rdata_in),
        .rdata_out (rdata_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        req      = '0;
        lock     = '0;
        ce_in    = '0;
        wbe_in   = '0;
        addr_in  = '0;
        wdata_in = '0;
        rdata_in = '0;
        tick();
        tick();

        // Reset state
        chk("rst_gnt",    64'(gnt), 64'h0);
        chk("rst_gnt_id", 64'(gnt_id), 64'h0);
        chk("rst_busy",   64'(busy), 64'h0);
        chk("rst_ce",     64'(ce_out), 64'h0);
        chk("rst_addr",   64'(addr_out), 64'h0);
        rdata_in = 32'hDEADBEEF;
        #1;
        chk("rdata_pass", 64'(rdata_out), 64'hDEADBEEF);

        // Single request from master 0, one-cycle grant latency
        rst                = 1'b1;
        req                = 2'b01;
        ce_in              = 2'b01;
        addr_in[31:0]      = 32'h0000_0100;
        addr_in[63:32]     = 32'h0000_0200;
        wdata_in[31:0]     = 32'h1111_1111;
        wdata_in[63:32]    = 32'h2222_2222;
        wbe_in[3:0]        = 4'h3;
        #1;
        chk("lat_gnt_before", 64'(gnt), 64'h0);
        tick();
        chk("t1_gnt",    64'(gnt), 64'h1);
        chk("t1_gnt_id", 64'(gnt_id), 64'h0);
        chk("t1_busy",   64'(busy), 64'h1);
        chk("t1_ce",     64'(ce_out), 64'h1);
        chk("t1_addr",   64'(addr_out), 64'h100);

        // Non-owner master 1 drives ce/wbe/data: must not reach the port
        ce_in       = 2'b11;
        wbe_in[7:4] = 4'hF;
        #1;
        chk("no_wbe",   64'(wbe_out), 64'h3);
        chk("no_wdata", 64'(wdata_out), 64'h1111_1111);
        ce_in = 2'b10;
        #1;
        chk("no_ce", 64'(ce_out), 64'h0);

        // Owner drops, nobody waiting -> idle
        req = 2'b00;
        tick();
        chk("idle_gnt",  64'(gnt), 64'h0);
        chk("idle_busy", 64'(busy), 64'h0);
        chk("idle_ce",   64'(ce_out), 64'h0);
        chk("idle_addr", 64'(addr_out), 64'h0);

        // Burst limit: both request from a fresh reset, master 0 first
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req = 2'b11;
        tick();
        chk("b_first", 64'(gnt), 64'h1);
        for (int i = 0; i < MAX_BURST - 1; i++) begin
            tick();
            chk("b_hold0", 64'(gnt), 64'h1);
        end
        tick();
        chk("b_hand1",  64'(gnt), 64'h2);
        chk("b_id1",    64'(gnt_id), 64'h1);
        chk("b_busy1",  64'(busy), 64'h1);
        chk("b_addr1",  64'(addr_out), 64'h200);
        for (int i = 0; i < MAX_BURST - 1; i++) begin
            tick();
            chk("b_hold1", 64'(gnt), 64'h2);
        end
        tick();
        chk("b_hand0", 64'(gnt), 64'h1);
        chk("b_id0",   64'(gnt_id), 64'h0);

        // Lock: master 0 keeps ownership well past the burst limit
        lock = 2'b01;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lk_hold", 64'(gnt), 64'h1);
        end
        lock = 2'b00;
        tick();
        chk("lk_release", 64'(gnt), 64'h2);

        // Master 1 owns, drops while master 0 requests -> zero-bubble handover
        req = 2'b01;
        tick();
        chk("drop_gnt",  64'(gnt), 64'h1);
        chk("drop_busy", 64'(busy), 64'h1);
        req = 2'b00;
        tick();
        chk("drop_idle_gnt",  64'(gnt), 64'h0);
        chk("drop_idle_busy", 64'(busy), 64'h0);
        chk("drop_idle_ce",   64'(ce_out), 64'h0);

        // Reset mid-burst while master 1 owns
        req   = 2'b10;
        ce_in = 2'b11;
        tick();
        chk("mr_own1", 64'(gnt), 64'h2);
        req = 2'b11;
        tick();
        tick();
        chk("mr_still1", 64'(gnt), 64'h2);
        rst = 1'b0;
        tick();
        chk("mr_gnt",  64'(gnt), 64'h0);
        chk("mr_busy", 64'(busy), 64'h0);
        chk("mr_ce",   64'(ce_out), 64'h0);
        chk("mr_id",   64'(gnt_id), 64'h0);
        rst = 1'b1;
        tick();
        chk("mr_first0", 64'(gnt), 64'h1);
        for (int i = 0; i < MAX_BURST - 1; i++) begin
            tick();
        end
        chk("mr_full_burst", 64'(gnt), 64'h1);
        tick();
        chk("mr_hand1", 64'(gnt), 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
